// File: rtl/byte_mem_access_unit_if.sv
// Bundles the CPU request side and the byte-wide memory side of byte_mem_access_unit.
// The slave modport is the access unit; the master modport is the CPU plus the attached memory.
interface byte_mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  Req;
  logic                  Write;
  logic [1:0]            Size;
  logic                  Signed;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [31:0]           WData;
  logic                  Busy;
  logic                  Done;
  logic                  Err;
  logic [31:0]           RData;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [7:0]            MemWData;
  logic                  MemRead;
  logic                  MemWrite;
  logic [7:0]            MemRData;

  modport master (
    output Req, Write, Size, Signed, Addr, WData, MemRData,
    input  Busy, Done, Err, RData, MemAddr, MemWData, MemRead, MemWrite
  );

  modport slave (
    input  Req, Write, Size, Signed, Addr, WData, MemRData,
    output Busy, Done, Err, RData, MemAddr, MemWData, MemRead, MemWrite
  );

endinterface

// File: rtl/byte_mem_access_unit.sv
// Big-endian byte/halfword/word load-store initiator driving a byte-wide memory port,
// one byte per cycle, with alignment, size and range checking before any memory cycle.
module byte_mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 1024
) (
  input logic                    Clock,
  input logic                    Reset_n,
  byte_mem_access_unit_if.slave  bus
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LastAddr = AW1'(MEM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StFinish} state_e;

  state_e                stateQ;
  logic                  writeQ;
  logic [1:0]            sizeQ;
  logic                  signedQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [31:0]           wDataQ;
  logic [2:0]            nQ;
  logic [1:0]            cntQ;
  logic [31:0]           accQ;
  logic                  errQ;
  logic [31:0]           rDataQ;
  logic [ADDR_WIDTH-1:0] memAddrQ;
  logic [7:0]            memWDataQ;
  logic                  memReadQ;
  logic                  memWriteQ;

  logic [2:0]            reqN;
  logic [ADDR_WIDTH:0]   reqEnd;
  logic                  reqErr;
  logic [31:0]           accNext;
  logic [2:0]            cntNext;
  logic                  isLast;

  // Byte (n-1-i) of the store data, counted from the LSB: byte 0 of the access is the MSB.
  function automatic logic [7:0] byteSel(logic [31:0] d, logic [2:0] n, logic [2:0] i);
    logic [2:0] idx;
    idx = n - 3'd1 - i;
    case (idx)
      3'd0:    return d[7:0];
      3'd1:    return d[15:8];
      3'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(logic [31:0] acc, logic [1:0] size, logic sgn);
    case (size)
      2'b00:   return {{24{sgn & acc[7]}}, acc[7:0]};
      2'b01:   return {{16{sgn & acc[15]}}, acc[15:0]};
      default: return acc;
    endcase
  endfunction

  always_comb begin
    reqN = 3'd1;
    case (bus.Size)
      2'b01:   reqN = 3'd2;
      2'b10:   reqN = 3'd4;
      default: reqN = 3'd1;
    endcase
  end

  // Computed one bit wider than the address so a request near the top of the space cannot wrap.
  assign reqEnd = {1'b0, bus.Addr} + AW1'(reqN) - AW1'(1);
  assign reqErr = (bus.Size == 2'b11)
               || (bus.Size == 2'b01 && bus.Addr[0])
               || (bus.Size == 2'b10 && bus.Addr[1:0] != 2'b00)
               || (reqEnd > LastAddr);

  assign accNext = {accQ[23:0], bus.MemRData};
  assign cntNext = {1'b0, cntQ} + 3'd1;
  assign isLast  = ({1'b0, cntQ} == nQ - 3'd1);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      stateQ    <= StIdle;
      writeQ    <= 1'b0;
      sizeQ     <= 2'b00;
      signedQ   <= 1'b0;
      addrQ     <= '0;
      wDataQ    <= '0;
      nQ        <= 3'd0;
      cntQ      <= 2'd0;
      accQ      <= '0;
      errQ      <= 1'b0;
      rDataQ    <= '0;
      memAddrQ  <= '0;
      memWDataQ <= '0;
      memReadQ  <= 1'b0;
      memWriteQ <= 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (bus.Req) begin
            writeQ  <= bus.Write;
            sizeQ   <= bus.Size;
            signedQ <= bus.Signed;
            addrQ   <= bus.Addr;
            wDataQ  <= bus.WData;
            nQ      <= reqN;
            cntQ    <= 2'd0;
            accQ    <= '0;
            if (reqErr) begin
              stateQ <= StFinish;
              errQ   <= 1'b1;
              rDataQ <= '0;
            end else begin
              stateQ    <= StAccess;
              memAddrQ  <= bus.Addr;
              memReadQ  <= !bus.Write;
              memWriteQ <= bus.Write;
              if (bus.Write) begin
                memWDataQ <= byteSel(bus.WData, reqN, 3'd0);
              end
            end
          end
        end
        StAccess: begin
          if (!writeQ) begin
            accQ <= accNext;
          end
          if (isLast) begin
            stateQ    <= StFinish;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            rDataQ    <= writeQ ? 32'd0 : extendLoad(accNext, sizeQ, signedQ);
          end else begin
            cntQ     <= cntNext[1:0];
            memAddrQ <= addrQ + ADDR_WIDTH'(cntNext);
            if (writeQ) begin
              memWDataQ <= byteSel(wDataQ, nQ, cntNext);
            end
          end
        end
        StFinish: begin
          stateQ <= StIdle;
          errQ   <= 1'b0;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign bus.Busy     = (stateQ != StIdle);
  assign bus.Done     = (stateQ == StFinish);
  assign bus.Err      = errQ;
  assign bus.RData    = rDataQ;
  assign bus.MemAddr  = memAddrQ;
  assign bus.MemWData = memWDataQ;
  assign bus.MemRead  = memReadQ;
  // Gated with reset so a pending byte write is cancelled the instant reset asserts.
  assign bus.MemWrite = memWriteQ & Reset_n;

endmodule

// File: tb/tb_byte_mem_access_unit.sv
// Scoreboard bench: requests push expected responses; a monitor checks each Done pulse,
// the latency from acceptance and the address sequence of every memory cycle.
module tb_byte_mem_access_unit;

  logic Clock = 1'b0;
  logic Reset_n;

  byte_mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

  byte_mem_access_unit #(
    .ADDR_WIDTH(32),
    .MEM_BYTES (1024)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  logic [7:0] mem [1024];

  assign bus.MemRData = (bus.MemAddr < 32'd1024) ? mem[bus.MemAddr[9:0]] : 8'h00;

  always @(posedge Clock) begin
    if (bus.MemWrite && bus.MemAddr < 32'd1024) mem[bus.MemAddr[9:0]] = bus.MemWData;
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nMem;
  } exp_t;

  exp_t expQ[$];
  int nChecks = 0;
  int nFails  = 0;

  int          cyc = 0;
  int          accCyc = 0;
  int          memCyc = 0;
  logic [31:0] accAddr = '0;
  logic        accW = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge Clock) begin
    if (Reset_n) begin
      if (bus.MemRead || bus.MemWrite) begin
        check("mem_addr", bus.MemAddr, accAddr + 32'(memCyc));
        check("mem_dir", {31'd0, bus.MemRead}, {31'd0, !accW});
        memCyc++;
      end
      if (bus.Done) begin
        if (expQ.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          check({e.name, "_rdata"}, bus.RData, e.rdata);
          check({e.name, "_err"}, {31'd0, bus.Err}, {31'd0, e.err});
          check({e.name, "_latency"}, 32'(cyc - accCyc), 32'(e.lat));
          check({e.name, "_memcycles"}, 32'(memCyc), 32'(e.nMem));
        end
      end
      if (!bus.Busy && bus.Req) begin
        accCyc  = cyc;
        accAddr = bus.Addr;
        accW    = bus.Write;
        memCyc  = 0;
      end
      cyc++;
    end
  end

  task automatic waitIdle(input string name);
    for (int k = 0; k < 20; k++) begin
      @(posedge Clock);
      if (expQ.size() == 0) break;
    end
    check({name, "_completed"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
    #1;
  endtask

  task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] expR,
                       input logic expE, input int lat, input int nMem);
    exp_t e;
    e.name = name; e.rdata = expR; e.err = expE; e.lat = lat; e.nMem = nMem;
    expQ.push_back(e);
    @(posedge Clock); #1;
    bus.Req = 1'b1; bus.Write = wr; bus.Size = sz; bus.Signed = sg; bus.Addr = addr;
    bus.WData = wd;
    @(posedge Clock); #1;
    // Scramble the request lines: only the captured copy may be used from here on.
    bus.Req = 1'b0; bus.Write = ~wr; bus.Size = ~sz; bus.Signed = ~sg; bus.Addr = ~addr;
    bus.WData = ~wd;
    waitIdle(name);
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.Done}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.Err}, 32'd0);
    check({tag, "_memread"}, {31'd0, bus.MemRead}, 32'd0);
    check({tag, "_memwrite"}, {31'd0, bus.MemWrite}, 32'd0);
    check({tag, "_rdata"}, bus.RData, 32'd0);
    check({tag, "_memaddr"}, bus.MemAddr, 32'd0);
    check({tag, "_memwdata"}, {24'd0, bus.MemWData}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
    mem[0] = 8'h02; mem[1] = 8'h12; mem[2] = 8'h08; mem[3] = 8'h04;
    mem[5] = 8'h9C;
    mem[1020] = 8'h7F; mem[1021] = 8'h00; mem[1022] = 8'h80; mem[1023] = 8'h01;

    Reset_n = 1'b0;
    bus.Req = 1'b0; bus.Write = 1'b0; bus.Size = 2'b00; bus.Signed = 1'b0;
    bus.Addr = '0; bus.WData = '0;
    #12;
    checkOutputsZero("reset");
    @(posedge Clock); #1;
    Reset_n = 1'b1;

    issue("word_load_0",  1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h02120804, 1'b0, 5, 4);
    check("rdata_held", bus.RData, 32'h02120804);
    issue("sbyte_load_5", 1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 32'hFFFFFF9C, 1'b0, 2, 1);
    issue("ubyte_load_5", 1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 32'h0000009C, 1'b0, 2, 1);
    issue("word_store_8", 1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 32'd0, 1'b0, 5, 4);
    check("store_bytes_8", {mem[8], mem[9], mem[10], mem[11]}, 32'hDEADBEEF);
    issue("shalf_load_10", 1'b0, 2'b01, 1'b1, 32'd10, 32'd0, 32'hFFFFBEEF, 1'b0, 3, 2);
    issue("byte_store_20", 1'b1, 2'b00, 1'b0, 32'd20, 32'h123456AB, 32'd0, 1'b0, 2, 1);
    check("store_byte_20", {24'd0, mem[20]}, 32'h000000AB);
    issue("half_store_22", 1'b1, 2'b01, 1'b0, 32'd22, 32'hCAFE1234, 32'd0, 1'b0, 3, 2);
    check("store_half_22", {16'd0, mem[22], mem[23]}, 32'h00001234);
    issue("uhalf_load_1022", 1'b0, 2'b01, 1'b0, 32'd1022, 32'd0, 32'h00008001, 1'b0, 3, 2);
    issue("word_load_1020", 1'b0, 2'b10, 1'b1, 32'd1020, 32'd0, 32'h7F008001, 1'b0, 5, 4);
    issue("err_word_6",   1'b0, 2'b10, 1'b0, 32'd6, 32'd0, 32'd0, 1'b1, 1, 0);
    issue("err_half_1021", 1'b0, 2'b01, 1'b0, 32'd1021, 32'd0, 32'd0, 1'b1, 1, 0);
    issue("err_size_11",  1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1, 0);
    issue("err_byte_1024", 1'b1, 2'b00, 1'b0, 32'd1024, 32'h55, 32'd0, 1'b1, 1, 0);
    issue("err_word_top", 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1, 1, 0);
    check("err_store_untouched", {24'd0, mem[1023]}, 32'h00000001);

    // Reset during the second byte of a word store.
    for (int i = 16; i < 20; i++) mem[i] = 8'hA5;
    @(posedge Clock); #1;
    bus.Req = 1'b1; bus.Write = 1'b1; bus.Size = 2'b10; bus.Signed = 1'b0;
    bus.Addr = 32'd16; bus.WData = 32'h11223344;
    @(posedge Clock); #1;
    bus.Req = 1'b0;
    @(posedge Clock); #2;
    Reset_n = 1'b0;
    #1;
    checkOutputsZero("mid_reset");
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    check("reset_store_bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'h11A5A5A5);
    issue("post_reset_load", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h02120804, 1'b0, 5, 4);

    // Req held high: the second load is accepted only in the idle cycle after Done.
    begin
      exp_t e;
      e.name = "held_req_a"; e.rdata = 32'h02120804; e.err = 1'b0; e.lat = 5; e.nMem = 4;
      expQ.push_back(e);
      e.name = "held_req_b";
      expQ.push_back(e);
    end
    @(posedge Clock); #1;
    bus.Req = 1'b1; bus.Write = 1'b0; bus.Size = 2'b10; bus.Signed = 1'b0; bus.Addr = 32'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (bus.Done) break;
    end
    check("held_first_done", {31'd0, bus.Done}, 32'd1);
    @(negedge Clock);
    check("held_gap_busy_low", {31'd0, bus.Busy}, 32'd0);
    @(posedge Clock); #1;
    bus.Req = 1'b0;
    @(negedge Clock);
    check("held_second_busy", {31'd0, bus.Busy}, 32'd1);
    waitIdle("held_req");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/byte_mem_access_unit.md
Name: byte_mem_access_unit

Overview:
- Initiator side of the byte-addressed, big-endian memory interface used by the multicycle DLX datapath.
- Accepts one CPU load/store request (byte, halfword or word) and drives a byte-wide memory port for one byte per cycle.
- The memory port has a combinational read and a write on the rising clock edge.
- Assembles big-endian read data with sign or zero extension, splits store data into bytes, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, width of the CPU and memory address buses.
- MEM_BYTES, 1024, number of bytes in the attached memory; highest legal byte address is MEM_BYTES-1.

Ports:
- Clock  input  1  single clock for the whole block; rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Req  input  1  request strobe; sampled only in IDLE.
- Write  input  1  1 = store, 0 = load.
- Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- Signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- Addr  input  ADDR_WIDTH  byte address of the access.
- WData  input  32  store data, right-justified.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  valid with Done; high for a misaligned, illegal-size or out-of-range request.
- RData  output  32  load result; valid from Done and held until the next accepted request.
- MemAddr  output  ADDR_WIDTH  byte address driven to memory.
- MemWData  output  8  byte driven to memory.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- MemRData  input  8  combinational read byte from memory.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State goes to IDLE.
  - Busy, Done, Err, MemRead, MemWrite = 0.
  - RData, MemAddr, MemWData = 0.
  - Byte counter and all captured request fields are cleared.
  - Reset asserted mid-access aborts at once: MemWrite drops combinationally with reset, so no partial byte is written after reset is asserted.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE:
  - When Req=1, capture Write, Size, Signed, Addr and WData, and set N = 1/2/4 for byte/half/word.
  - Error check:
    - Size=11 is an error.
    - A halfword with Addr[0]=1 is an error.
    - A word with Addr[1:0]!=0 is an error.
    - Addr+N-1 > MEM_BYTES-1 is an error; compute it at ADDR_WIDTH+1 bits so it cannot wrap.
  - On error go to FINISH with Err=1; no memory cycle is issued. Otherwise clear the accumulator and go to ACCESS with counter i=0.
- ACCESS, one byte per cycle, i = 0..N-1:
  - MemAddr = Addr+i.
  - Load: MemRead=1. At the clock edge, accumulator = {accumulator[23:0], MemRData}.
  - Store: MemWrite=1, MemWData = byte (N-1-i) of WData, counting from the LSB. So byte 0 of a word store is WData[31:24], and a byte store writes WData[7:0].
  - After the edge where i=N-1, go to FINISH.
- FINISH:
  - Done=1 for exactly one cycle.
  - For a load with no error, RData is the low 8N bits of the accumulator, extended to 32 bits (sign bit is bit 8N-1 when Signed=1, zero otherwise).
  - On an error or a store, RData = 0.
  - Next state is IDLE.
- Outputs in IDLE and FINISH: MemRead = MemWrite = 0, and MemAddr/MemWData hold their last values.
- Latency: Req sampled at edge T gives Done high in the cycle after edge T+N. Totals are 2, 3 and 5 cycles for byte, half and word; an error request takes 1 cycle.
- Back-to-back: a new Req is accepted in the cycle after Done (IDLE). Req while Busy=1 is ignored and not queued.
- Request inputs may change after acceptance; only the captured copies are used.
- Err is registered and meaningful only while Done=1; otherwise it is 0.

Test Plan:
- Word load at Addr=0 with the bench memory holding bytes 02 12 08 04 -> MemRead high for 4 cycles at addresses 0..3, Done in cycle 5, RData=0x02120804, Err=0.
- Signed byte load at Addr=5 with byte 0x9C -> RData=0xFFFFFF9C. The same load with Signed=0 -> RData=0x0000009C, latency 2 cycles.
- Word store WData=0xDEADBEEF at Addr=8 -> MemWrite 4 cycles, bytes DE AD BE EF at addresses 8..11. A following signed half load at Addr=10 -> RData=0xFFFFBEEF.
- Misaligned word load at Addr=6, then half load at Addr=1021 with MEM_BYTES=1024, then Size=11 -> each gives Done+Err after 1 cycle with no MemRead/MemWrite pulse.
- Reset_n pulled low during the 2nd byte of a word store at Addr=16 -> MemWrite drops immediately, only byte 16 is modified, and all outputs are 0. After release, a word load at Addr=0 behaves normally.
- Req held high continuously during a word load -> the second request is accepted only in the cycle after Done, with no overlap and Busy low for exactly that one cycle.
